regfile_writeback_sink: RTL and testbench
=========================================

Name: regfile_writeback_sink

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs: a 32-entry register file with two read ports for the decode stage.
- Adds a per-register pending-write scoreboard:
  - Decode marks a destination as pending at issue.
  - Writeback retires the pending mark.
  - Decode stalls while a source operand is still pending.
- Sits between the MEM/WB register (write side) and the ID stage / ID-EX register (read side).

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- CNT_W, 2, pending counter width per register; max in-flight writes per register = 2**CNT_W-1 = 3.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous reset, active-low.
- i_WB  input  1  writeback enable from MEM/WB.
- i_Rw  input  ADDR_W  writeback destination index.
- i_data  input  DATA_W  writeback data.
- i_Ra  input  ADDR_W  read port A index.
- i_Rb  input  ADDR_W  read port B index.
- i_use_a  input  1  decode uses operand A this cycle.
- i_use_b  input  1  decode uses operand B this cycle.
- i_issue  input  1  decode issues an instruction that will write i_issue_Rw.
- i_issue_Rw  input  ADDR_W  destination of the issuing instruction.
- o_busA  output  DATA_W  read data A (combinational).
- o_busB  output  DATA_W  read data B (combinational).
- o_stall  output  1  operand hazard, decode must hold (combinational).
- o_full  output  1  pending counter of i_issue_Rw saturated; issue is not accepted (combinational).

Behaviour:
- Single clock i_clk; reset is synchronous, active-low on i_rst_n.
- Reset (i_rst_n=0 at posedge):
  - All registers <= 0 and all pending counters <= 0.
  - Reads during and after reset return 0; o_stall=0 and o_full=0 once counters are 0.
- Register 0:
  - Reads always 0.
  - Writes to index 0 are ignored.
  - Issue to index 0 is ignored; counter 0 is never nonzero.
  - o_full is never asserted for index 0.
- Write: at posedge with i_rst_n=1, i_WB=1 and i_Rw!=0, regs[i_Rw] <= i_data. Data is visible on the read ports the following cycle, or the same cycle with the optional feature.
- Read: o_busA = (i_Ra==0) ? 0 : regs[i_Ra]; o_busB likewise. Zero latency, no clock.
- Scoreboard counter cnt[r], per posedge (i_rst_n=1):
  - inc = i_issue && i_issue_Rw==r && r!=0 && cnt[r]!=max
  - dec = i_WB && i_Rw==r && r!=0 && cnt[r]!=0
  - inc && !dec -> cnt+1; dec && !inc -> cnt-1; both or neither -> unchanged.
  - Writeback to a register with cnt==0: data still written, counter stays 0 (no underflow, no error).
  - Issue with cnt==max: o_full=1, counter unchanged; decode must hold the issue.
  - o_full = i_issue && i_issue_Rw!=0 && cnt[i_issue_Rw]==max.
- Hazard, without the optional feature:
  - hazA = i_use_a && i_Ra!=0 && cnt[i_Ra]!=0; hazB likewise.
  - o_stall = hazA || hazB || o_full.
- Simultaneous issue and writeback to the same register: counter unchanged, data written.
- Reset asserted mid-operation: all state cleared at that edge regardless of i_WB or i_issue; in-flight writes are lost.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined:
  - Write-through forwarding: if i_WB && i_Rw!=0 && i_Rw==i_Ra, o_busA = i_data in the same cycle; port B likewise.
  - hazA relaxes to: i_use_a && i_Ra!=0 && (cnt[i_Ra]>1 || (cnt[i_Ra]==1 && !(i_WB && i_Rw==i_Ra))); hazB likewise.
- Undefined: read ports return stored values only; the hazard rule is as in Behaviour.

Test Plan:
- Reset then i_Ra=5, i_Rb=31 -> o_busA=0, o_busB=0, o_stall=0, o_full=0.
- i_WB=1, i_Rw=0, i_data=32'hDEADBEEF; next cycle i_Ra=0 -> o_busA=0. Also i_issue=1, i_issue_Rw=0, i_use_a=1, i_Ra=0 -> o_stall=0.
- Issue R7, then i_use_a=1, i_Ra=7 -> o_stall=1. Writeback R7 with 32'h12345678; next cycle o_stall=0, o_busA=32'h12345678. With REGFILE_WB_BYPASS_EN: o_stall=0 and o_busA=32'h12345678 already in the writeback cycle.
- Issue R3 three times -> cnt=3. Fourth issue -> o_full=1, o_stall=1. One writeback to R3 -> cnt=2, o_full=0 on retry.
- Same cycle issue R9 and writeback R9 with cnt[9]=1, data 32'hA5A5A5A5 -> cnt stays 1, regs[9]=32'hA5A5A5A5, subsequent read of R9 with i_use_a=1 -> o_stall=1.
- Registers loaded and cnt[4]=2, then i_rst_n=0 for one edge while i_WB=1, i_Rw=4 -> after edge all reads 0, cnt[4]=0, o_stall=0.

Source files
------------

// File: rtl/regfile_writeback_sink_if.sv
// rtl/regfile_writeback_sink_if.sv - MEM/WB write side and decode read/issue side bundle for the register file.
interface regfile_writeback_sink_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_WB;
  logic [ADDR_W-1:0] i_Rw;
  logic [DATA_W-1:0] i_data;
  logic [ADDR_W-1:0] i_Ra;
  logic [ADDR_W-1:0] i_Rb;
  logic              i_use_a;
  logic              i_use_b;
  logic              i_issue;
  logic [ADDR_W-1:0] i_issue_Rw;
  logic [DATA_W-1:0] o_busA;
  logic [DATA_W-1:0] o_busB;
  logic              o_stall;
  logic              o_full;

  modport master (
    output i_WB, i_Rw, i_data, i_Ra, i_Rb, i_use_a, i_use_b, i_issue, i_issue_Rw,
    input  o_busA, o_busB, o_stall, o_full
  );

  modport slave (
    input  i_WB, i_Rw, i_data, i_Ra, i_Rb, i_use_a, i_use_b, i_issue, i_issue_Rw,
    output o_busA, o_busB, o_stall, o_full
  );
endinterface

// File: rtl/regfile_writeback_sink.sv
// rtl/regfile_writeback_sink.sv - 32-entry register file with per-register pending-write scoreboard.
// Optional write-through forwarding and relaxed hazard check under REGFILE_WB_BYPASS_EN.
module regfile_writeback_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  regfile_writeback_sink_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;
  logic              wb_en;
  logic              haz_a;
  logic              haz_b;
  logic              full;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign wb_en = bus.i_WB && (bus.i_Rw != '0);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      inc[r] = bus.i_issue && (bus.i_issue_Rw == ADDR_W'(r)) && (cnt_q[r] != CNT_MAX);
      dec[r] = bus.i_WB && (bus.i_Rw == ADDR_W'(r)) && (cnt_q[r] != '0);
    end
  end

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wb_en) begin
      regs_d[bus.i_Rw] = bus.i_data;
    end
    for (int r = 1; r < DEPTH; r++) begin
      if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec[r] && !inc[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    // Index 0 is hardwired: never holds data, never pending.
    regs_d[0] = '0;
    cnt_d[0]  = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

  always_comb begin
    rd_a = (bus.i_Ra == '0) ? '0 : regs_q[bus.i_Ra];
    rd_b = (bus.i_Rb == '0) ? '0 : regs_q[bus.i_Rb];
`ifdef REGFILE_WB_BYPASS_EN
    if (wb_en && (bus.i_Rw == bus.i_Ra)) rd_a = bus.i_data;
    if (wb_en && (bus.i_Rw == bus.i_Rb)) rd_b = bus.i_data;
`endif
  end

  always_comb begin
`ifdef REGFILE_WB_BYPASS_EN
    // A single outstanding write retiring this cycle is covered by the forward path.
    haz_a = bus.i_use_a && (bus.i_Ra != '0) &&
            ((cnt_q[bus.i_Ra] > CNT_W'(1)) ||
             ((cnt_q[bus.i_Ra] == CNT_W'(1)) && !(bus.i_WB && (bus.i_Rw == bus.i_Ra))));
    haz_b = bus.i_use_b && (bus.i_Rb != '0) &&
            ((cnt_q[bus.i_Rb] > CNT_W'(1)) ||
             ((cnt_q[bus.i_Rb] == CNT_W'(1)) && !(bus.i_WB && (bus.i_Rw == bus.i_Rb))));
`else
    haz_a = bus.i_use_a && (bus.i_Ra != '0) && (cnt_q[bus.i_Ra] != '0);
    haz_b = bus.i_use_b && (bus.i_Rb != '0) && (cnt_q[bus.i_Rb] != '0);
`endif
    full = bus.i_issue && (bus.i_issue_Rw != '0) && (cnt_q[bus.i_issue_Rw] == CNT_MAX);
  end

  assign bus.o_busA  = rd_a;
  assign bus.o_busB  = rd_b;
  assign bus.o_full  = full;
  assign bus.o_stall = haz_a || haz_b || full;
endmodule

// File: tb/tb_regfile_writeback_sink.sv
// tb/tb_regfile_writeback_sink.sv - directed and random checks of regfile_writeback_sink against an array model.
module tb_regfile_writeback_sink;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  int unsigned m_regs [32];
  int          m_cnt  [32];

  regfile_writeback_sink_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_writeback_sink #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int ra);
    if (ra == 0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
    if (bus.i_WB && bus.i_Rw != 0 && int'(bus.i_Rw) == ra) return bus.i_data;
`endif
    return m_regs[ra];
  endfunction

  function automatic logic exp_haz(input logic use_it, input int ra);
    if (!use_it || ra == 0) return 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    return (m_cnt[ra] > 1) || (m_cnt[ra] == 1 && !(bus.i_WB && int'(bus.i_Rw) == ra));
`else
    return m_cnt[ra] != 0;
`endif
  endfunction

  task automatic settle_check(input string tag);
    logic e_full;
    #2;
    e_full = bus.i_issue && bus.i_issue_Rw != 0 && m_cnt[bus.i_issue_Rw] == 3;
    chk({tag, ".busA"},  bus.o_busA, exp_read(int'(bus.i_Ra)));
    chk({tag, ".busB"},  bus.o_busB, exp_read(int'(bus.i_Rb)));
    chk({tag, ".full"},  {31'b0, bus.o_full}, {31'b0, e_full});
    chk({tag, ".stall"}, {31'b0, bus.o_stall},
        {31'b0, exp_haz(bus.i_use_a, int'(bus.i_Ra)) || exp_haz(bus.i_use_b, int'(bus.i_Rb)) || e_full});
  endtask

  task automatic tick();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 0;
        m_cnt[r]  = 0;
      end
    end else begin
      int inc_r, dec_r;
      inc_r = (bus.i_issue && bus.i_issue_Rw != 0 && m_cnt[bus.i_issue_Rw] != 3) ? int'(bus.i_issue_Rw) : 0;
      dec_r = (bus.i_WB && bus.i_Rw != 0 && m_cnt[bus.i_Rw] != 0) ? int'(bus.i_Rw) : 0;
      if (bus.i_WB && bus.i_Rw != 0) m_regs[bus.i_Rw] = bus.i_data;
      if (inc_r != 0) m_cnt[inc_r] = m_cnt[inc_r] + 1;
      if (dec_r != 0) m_cnt[dec_r] = m_cnt[dec_r] - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_WB = 0; bus.i_Rw = 0; bus.i_data = 0; bus.i_Ra = 0; bus.i_Rb = 0;
    bus.i_use_a = 0; bus.i_use_b = 0; bus.i_issue = 0; bus.i_issue_Rw = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    bus.i_Ra = 5; bus.i_Rb = 31;
    settle_check("reset");
    chk("reset.busA0", bus.o_busA, 32'h0);
    chk("reset.busB0", bus.o_busB, 32'h0);
    chk("reset.stall0", {31'b0, bus.o_stall}, 32'h0);
    tick();
    rst_n = 1;

    idle(); bus.i_WB = 1; bus.i_Rw = 0; bus.i_data = 32'hDEADBEEF;
    settle_check("wr0"); tick();
    idle(); bus.i_Ra = 0; bus.i_use_a = 1; bus.i_issue = 1; bus.i_issue_Rw = 0;
    settle_check("rd0");
    chk("rd0.busA", bus.o_busA, 32'h0);
    chk("rd0.stall", {31'b0, bus.o_stall}, 32'h0);
    tick();

    idle(); bus.i_issue = 1; bus.i_issue_Rw = 7;
    settle_check("iss7"); tick();
    idle(); bus.i_use_a = 1; bus.i_Ra = 7;
    settle_check("haz7");
    chk("haz7.stall", {31'b0, bus.o_stall}, 32'h1);
    tick();
    bus.i_WB = 1; bus.i_Rw = 7; bus.i_data = 32'h12345678;
    settle_check("wb7");
`ifdef REGFILE_WB_BYPASS_EN
    chk("wb7.stall", {31'b0, bus.o_stall}, 32'h0);
    chk("wb7.busA", bus.o_busA, 32'h12345678);
`else
    chk("wb7.stall", {31'b0, bus.o_stall}, 32'h1);
`endif
    tick();
    bus.i_WB = 0;
    settle_check("post7");
    chk("post7.stall", {31'b0, bus.o_stall}, 32'h0);
    chk("post7.busA", bus.o_busA, 32'h12345678);
    tick();

    idle(); bus.i_issue = 1; bus.i_issue_Rw = 3;
    for (int i = 0; i < 3; i++) begin
      settle_check("iss3"); tick();
    end
    settle_check("full3");
    chk("full3.full", {31'b0, bus.o_full}, 32'h1);
    chk("full3.stall", {31'b0, bus.o_stall}, 32'h1);
    tick();
    idle(); bus.i_WB = 1; bus.i_Rw = 3; bus.i_data = 32'h33;
    settle_check("wb3"); tick();
    idle(); bus.i_issue = 1; bus.i_issue_Rw = 3;
    settle_check("retry3");
    chk("retry3.full", {31'b0, bus.o_full}, 32'h0);
    tick();

    idle(); bus.i_issue = 1; bus.i_issue_Rw = 9;
    settle_check("iss9"); tick();
    bus.i_WB = 1; bus.i_Rw = 9; bus.i_data = 32'hA5A5A5A5;
    settle_check("both9"); tick();
    idle(); bus.i_use_a = 1; bus.i_Ra = 9;
    settle_check("rd9");
    chk("rd9.stall", {31'b0, bus.o_stall}, 32'h1);
    chk("rd9.busA", bus.o_busA, 32'hA5A5A5A5);
    tick();

    idle(); bus.i_issue = 1; bus.i_issue_Rw = 4; bus.i_WB = 1; bus.i_Rw = 5; bus.i_data = 32'h55;
    settle_check("iss4a"); tick();
    bus.i_WB = 0;
    settle_check("iss4b"); tick();
    idle(); rst_n = 0; bus.i_WB = 1; bus.i_Rw = 4; bus.i_data = 32'h44;
    tick();
    rst_n = 1; idle(); bus.i_Ra = 4; bus.i_Rb = 9; bus.i_use_a = 1; bus.i_use_b = 1;
    settle_check("midrst");
    chk("midrst.busA", bus.o_busA, 32'h0);
    chk("midrst.busB", bus.o_busB, 32'h0);
    chk("midrst.stall", {31'b0, bus.o_stall}, 32'h0);
    tick();

    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.i_WB = $urandom_range(0, 1);
      bus.i_Rw = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      bus.i_data = $urandom;
      bus.i_Ra = 5'($urandom_range(0, 5));
      bus.i_Rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
      bus.i_use_a = $urandom_range(0, 1);
      bus.i_use_b = $urandom_range(0, 1);
      bus.i_issue = ($urandom_range(0, 2) != 0);
      bus.i_issue_Rw = 5'($urandom_range(0, 5));
      settle_check("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
